cache_mem_arbiter: RTL

//  - Shares the single 256-bit cacheline adaptor port between the I-cache (read-only) and D-cache (read/write).
//  - Sits between the L1 caches and cacheline_adaptor; exactly one cache owns the adaptor per line transaction.
//  - Registers the returned line and pulses resp back to the granted requester only.

---
 rtl/cache_mem_arbiter_if.sv | 33 +++
 rtl/cache_mem_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Bundles the I-cache, D-cache and cacheline-adaptor signals shared by cache_mem_arbiter.
// slave: the arbiter's view. master: the caches-plus-adaptor environment's view.
interface cache_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_line;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wline;
  logic [LINE_W-1:0] d_line;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wline;
  logic [LINE_W-1:0] mem_rline;
  logic              mem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wline, mem_rline, mem_resp,
    output i_line, i_resp, d_line, d_resp, mem_read, mem_write, mem_address, mem_wline
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wline, mem_rline, mem_resp,
    input  i_line, i_resp, d_line, d_resp, mem_read, mem_write, mem_address, mem_wline
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Grants the single cacheline adaptor port to the I-cache or D-cache, one line at a time.
// Define ARB_PERF_CNT_EN to add grant and conflict counters.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_W     = 256,
  parameter int unsigned FIXED_PRIO = 0
) (
  input logic                clk,
  input logic                rst,
  cache_mem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]        i_grant_cnt,
  output logic [31:0]        d_grant_cnt,
  output logic [31:0]        conflict_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StIBusy, StDBusy, StDone} state_e;

  state_e            r_state, w_state;
  logic              r_rr_last_d, w_rr_last_d;  // 1: D-cache owned the adaptor last
  logic              r_mem_read, w_mem_read;
  logic              r_mem_write, w_mem_write;
  logic [ADDR_W-1:0] r_mem_address, w_mem_address;
  logic [LINE_W-1:0] r_mem_wline, w_mem_wline;
  logic [LINE_W-1:0] r_i_line, w_i_line;
  logic [LINE_W-1:0] r_d_line, w_d_line;
  logic              r_i_resp, w_i_resp;
  logic              r_d_resp, w_d_resp;
  logic              w_i_req, w_d_req, w_grant_i, w_grant_d;

  always_comb begin
    w_i_req   = bus.i_read;
    w_d_req   = bus.d_read | bus.d_write;
    w_grant_d = (r_state == StIdle) && w_d_req &&
                (!w_i_req || (FIXED_PRIO != 0) || !r_rr_last_d);
    w_grant_i = (r_state == StIdle) && w_i_req && !w_grant_d;
  end

  always_comb begin
    w_state       = r_state;
    w_rr_last_d   = r_rr_last_d;
    w_mem_read    = r_mem_read;
    w_mem_write   = r_mem_write;
    w_mem_address = r_mem_address;
    w_mem_wline   = r_mem_wline;
    w_i_line      = r_i_line;
    w_d_line      = r_d_line;
    w_i_resp      = r_i_resp;
    w_d_resp      = r_d_resp;
    unique case (r_state)
      StIdle: begin
        if (w_grant_d) begin
          // A simultaneous read and write is illegal; the write is honoured.
          w_state       = StDBusy;
          w_mem_write   = bus.d_write;
          w_mem_read    = !bus.d_write;
          w_mem_address = bus.d_address;
          w_mem_wline   = bus.d_wline;
        end else if (w_grant_i) begin
          w_state       = StIBusy;
          w_mem_read    = 1'b1;
          w_mem_write   = 1'b0;
          w_mem_address = bus.i_address;
        end
      end
      StIBusy: begin
        if (bus.mem_resp) begin
          w_state     = StDone;
          w_mem_read  = 1'b0;
          w_mem_write = 1'b0;
          w_i_line    = bus.mem_rline;
          w_i_resp    = 1'b1;
          w_rr_last_d = 1'b0;
        end
      end
      StDBusy: begin
        if (bus.mem_resp) begin
          w_state     = StDone;
          w_mem_read  = 1'b0;
          w_mem_write = 1'b0;
          w_d_line    = bus.mem_rline;
          w_d_resp    = 1'b1;
          w_rr_last_d = 1'b1;
        end
      end
      StDone: begin
        // The idle cycle lets the requester drop its request before it is sampled again.
        w_state  = StIdle;
        w_i_resp = 1'b0;
        w_d_resp = 1'b0;
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= StIdle;
      r_rr_last_d   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wline   <= '0;
      r_i_line      <= '0;
      r_d_line      <= '0;
      r_i_resp      <= 1'b0;
      r_d_resp      <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_rr_last_d   <= w_rr_last_d;
      r_mem_read    <= w_mem_read;
      r_mem_write   <= w_mem_write;
      r_mem_address <= w_mem_address;
      r_mem_wline   <= w_mem_wline;
      r_i_line      <= w_i_line;
      r_d_line      <= w_d_line;
      r_i_resp      <= w_i_resp;
      r_d_resp      <= w_d_resp;
    end
  end

  assign bus.mem_read    = r_mem_read;
  assign bus.mem_write   = r_mem_write;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_wline   = r_mem_wline;
  assign bus.i_line      = r_i_line;
  assign bus.i_resp      = r_i_resp;
  assign bus.d_line      = r_d_line;
  assign bus.d_resp      = r_d_resp;

`ifdef ARB_PERF_CNT_EN
  logic        w_conflict;
  logic [31:0] r_i_grant_cnt, r_d_grant_cnt, r_conflict_cnt;

  assign w_conflict = (r_state == StIdle) && w_i_req && w_d_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i_grant_cnt  <= '0;
      r_d_grant_cnt  <= '0;
      r_conflict_cnt <= '0;
    end else begin
      r_i_grant_cnt  <= r_i_grant_cnt + 32'(w_grant_i);
      r_d_grant_cnt  <= r_d_grant_cnt + 32'(w_grant_d);
      r_conflict_cnt <= r_conflict_cnt + 32'(w_conflict);
    end
  end

  assign i_grant_cnt  = r_i_grant_cnt;
  assign d_grant_cnt  = r_d_grant_cnt;
  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
